cu_seq_decode: RTL
==================

# cu_seq_decode

Registered, parametrised decode-stage control unit for the PDA pipeline. It sits between the fetch/decode register and the deco→exe pipeline register. It turns {op, cmd, imm} into the deco_exe_cu_signals bundle plus the register-source and link controls. It adds what the combinational decode lacks: valid/stall handshake, multi-cycle issue for MUL/SIN/COS, branch-shadow squashing, and configurable latencies.

## Interface
- MUL_LAT, 3: cycles MUL occupies the execute unit (≥1).
- TRIG_LAT, 8: cycles SIN/COS occupy the trig unit (≥1).
- FLUSH_DEPTH, 2: accepted instructions squashed after a taken flow op (0..7).
- ALU_W, 4: aluControl width.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  decode slot holds an instruction.
- in_op  in  2  PROCESSING=00, MEMORY=01, FLOW=10.
- in_cmd  in  5  processing cmd; MEMORY uses [1:0]; FLOW uses [0].
- in_imm  in  1  WITH_IMM=1.
- stall  out  1  upstream must hold the instruction; in_valid & ~stall = accept.
- out_valid  out  1  bundle below is a real instruction.
- ctrl  out  struct  deco_exe_cu_signals (pcSrc, regWrite, memToReg[1:0], memWrite, memPixWrite, aluControl[ALU_W-1:0], aluSrc, immSrc, flagWrite, branch, trigControl).
- reg_src_a1, reg_src_a2, b_link  out  1 each.
- illegal  out  1  sticky illegal-encoding flag (see Configuration).

## Operation
- Decode (all unlisted fields 0):
  - AND: regWrite, aluControl 0101, memToReg 01.
  - XOR: regWrite, aluControl 0100, memToReg 01.
  - SUB: regWrite, aluControl 0001, memToReg 01.
  - ADD: regWrite, aluControl 0010, memToReg 01.
  - ORR: regWrite, aluControl 0011, memToReg 01.
  - MOV: regWrite, aluControl 0000, memToReg 01.
  - LSL: regWrite, aluControl 0111, memToReg 01.
  - LSR: regWrite, aluControl 1000, memToReg 01.
  - MUL: regWrite, aluControl 0110, memToReg 01.
  - CMP: aluControl 0001, flagWrite.
  - SIN: regWrite, memToReg 11, trigControl 0.
  - COS: regWrite, memToReg 11, trigControl 1.
  - NOP: all zero.
- WITH_IMM on any processing op: aluSrc=1, immSrc=0.
- LDR: regWrite, aluSrc, aluControl 0010, memToReg 00.
- STR: memWrite, aluSrc, aluControl 0010, reg_src_a2.
- RDP: regWrite, memToReg 10.
- WRP: memPixWrite, reg_src_a2.
- B: branch, pcSrc.
- BL: branch, pcSrc, b_link, regWrite.
- FSM states:
  - RUN: on accept, register the decoded bundle.
    - MUL with MUL_LAT>1 → BUSY, cnt=MUL_LAT-1.
    - SIN/COS with TRIG_LAT>1 → BUSY, cnt=TRIG_LAT-1.
    - FLOW with FLUSH_DEPTH>0 → SHADOW, sq=FLUSH_DEPTH.
  - BUSY: stall=1, out_valid=0 (bubble, ctrl all 0). cnt decrements each cycle; at cnt==1 → RUN, so stall deasserts in the same cycle the counter expires.
  - SHADOW: stall=0. Each accepted instruction is squashed (out_valid=0, ctrl 0) and decrements sq; at sq==1 → RUN. Cycles without in_valid do not count.
- A flow op accepted in SHADOW is squashed and does not restart sq.
- No accept in RUN: out_valid=0, ctrl 0.

## Timing
- All outputs are registered: accept at edge N, bundle visible after edge N, valid for one cycle.
- stall is combinational from state only (state==BUSY), never from in_*.
- Reset (async assert, sync deassert expected): state RUN, cnt=0, sq=0, stall=0, out_valid=0, ctrl/reg_src/b_link all 0, illegal=0.
- Reset mid-BUSY/SHADOW aborts immediately; the first post-reset instruction decodes normally.
- Back-to-back single-cycle ops sustain 1 instruction/cycle.
- A multi-cycle op yields 1 valid cycle followed by LAT-1 bubbles.

## Configuration
- CU_ILLEGAL_TRAP_EN defined:
  - op=11 or processing cmd>01100 sets illegal (sticky until reset), forces NOP, out_valid=0.
  - The encoding is consumed (accepted) but no state transition occurs.
- Undefined: the same encodings decode as NOP with out_valid=1; illegal is tied 0.

## Test plan
- Reset then ADD, no imm, valid for 1 cycle → next cycle out_valid=1, regWrite=1, aluControl=0010, memToReg=01, aluSrc=0; following cycle out_valid=0.
- MUL with MUL_LAT=3, in_valid held → stall high 2 cycles after issue; next instruction accepted on cycle 3; exactly one MUL bundle emitted.
- COS with TRIG_LAT=8 → trigControl=1, memToReg=11; stall high 7 cycles; reset asserted at stall cycle 4 → stall=0 and out_valid=0 asynchronously.
- BL then ADD, SUB, ORR with FLUSH_DEPTH=2 → BL emitted with b_link=1, pcSrc=1; ADD/SUB squashed; ORR emitted.
- STR with imm → memWrite=1, aluSrc=1, reg_src_a2=1, regWrite=0.
- op=11 with CU_ILLEGAL_TRAP_EN → illegal=1 and stays 1, out_valid=0; without the macro → out_valid=1, all ctrl 0.

Source files
------------

// File: rtl/cu_seq_decode_if.sv
// rtl/cu_seq_decode_if.sv - decode slot handshake and deco->exe control bundle
interface cu_seq_decode_if #(
  parameter int ALU_W = 4
);
  typedef struct packed {
    logic             pcSrc;
    logic             regWrite;
    logic [1:0]       memToReg;
    logic             memWrite;
    logic             memPixWrite;
    logic [ALU_W-1:0] aluControl;
    logic             aluSrc;
    logic             immSrc;
    logic             flagWrite;
    logic             branch;
    logic             trigControl;
  } deco_exe_cu_signals_t;

  logic                 in_valid;
  logic [1:0]           in_op;
  logic [4:0]           in_cmd;
  logic                 in_imm;
  logic                 stall;
  logic                 out_valid;
  deco_exe_cu_signals_t ctrl;
  logic                 reg_src_a1;
  logic                 reg_src_a2;
  logic                 b_link;
  logic                 illegal;

  modport slave (
    input  in_valid, in_op, in_cmd, in_imm,
    output stall, out_valid, ctrl, reg_src_a1, reg_src_a2, b_link, illegal
  );

  modport master (
    output in_valid, in_op, in_cmd, in_imm,
    input  stall, out_valid, ctrl, reg_src_a1, reg_src_a2, b_link, illegal
  );
endinterface

// File: rtl/cu_seq_decode.sv
// rtl/cu_seq_decode.sv - registered decode control unit with multi-cycle issue and branch shadow
// Optional illegal-encoding trap: define CU_ILLEGAL_TRAP_EN.
module cu_seq_decode #(
  parameter int MUL_LAT     = 3,
  parameter int TRIG_LAT    = 8,
  parameter int FLUSH_DEPTH = 2,
  parameter int ALU_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  cu_seq_decode_if.slave   bus
);
  typedef struct packed {
    logic             pcSrc;
    logic             regWrite;
    logic [1:0]       memToReg;
    logic             memWrite;
    logic             memPixWrite;
    logic [ALU_W-1:0] aluControl;
    logic             aluSrc;
    logic             immSrc;
    logic             flagWrite;
    logic             branch;
    logic             trigControl;
  } ctrl_t;

  typedef enum logic [1:0] {S_RUN = 2'd0, S_BUSY = 2'd1, S_SHADOW = 2'd2} state_t;

  localparam int MAX_LAT = (MUL_LAT > TRIG_LAT) ? MUL_LAT : TRIG_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [1:0] OP_PROC = 2'b00;
  localparam logic [1:0] OP_MEM  = 2'b01;
  localparam logic [1:0] OP_FLOW = 2'b10;

  localparam logic [4:0] C_AND = 5'd0,  C_XOR = 5'd1,  C_SUB = 5'd2,  C_ADD = 5'd3;
  localparam logic [4:0] C_ORR = 5'd4,  C_MOV = 5'd5,  C_LSL = 5'd6,  C_LSR = 5'd7;
  localparam logic [4:0] C_MUL = 5'd8,  C_CMP = 5'd9,  C_SIN = 5'd10, C_COS = 5'd11;
  localparam logic [4:0] C_NOP = 5'd12;

  localparam logic [ALU_W-1:0] A_MOV = ALU_W'(0), A_SUB = ALU_W'(1), A_ADD = ALU_W'(2);
  localparam logic [ALU_W-1:0] A_ORR = ALU_W'(3), A_XOR = ALU_W'(4), A_AND = ALU_W'(5);
  localparam logic [ALU_W-1:0] A_MUL = ALU_W'(6), A_LSL = ALU_W'(7), A_LSR = ALU_W'(8);

`ifdef CU_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sq_q, sq_d;

  ctrl_t dec;
  logic  dec_a2, dec_link, dec_bad, dec_mul, dec_trig, dec_flow;
  logic  accept, trap;

  ctrl_t ctrl_q, ctrl_d;
  logic  out_valid_q, out_valid_d;
  logic  a2_q, a2_d, link_q, link_d;

  // Pure combinational decode of the slot contents; sequencing is layered on top.
  always_comb begin
    dec      = '0;
    dec_a2   = 1'b0;
    dec_link = 1'b0;
    dec_bad  = 1'b0;
    dec_mul  = 1'b0;
    dec_trig = 1'b0;
    dec_flow = 1'b0;
    case (bus.in_op)
      OP_PROC: begin
        case (bus.in_cmd)
          C_AND: begin dec.regWrite = 1'b1; dec.aluControl = A_AND; dec.memToReg = 2'b01; end
          C_XOR: begin dec.regWrite = 1'b1; dec.aluControl = A_XOR; dec.memToReg = 2'b01; end
          C_SUB: begin dec.regWrite = 1'b1; dec.aluControl = A_SUB; dec.memToReg = 2'b01; end
          C_ADD: begin dec.regWrite = 1'b1; dec.aluControl = A_ADD; dec.memToReg = 2'b01; end
          C_ORR: begin dec.regWrite = 1'b1; dec.aluControl = A_ORR; dec.memToReg = 2'b01; end
          C_MOV: begin dec.regWrite = 1'b1; dec.aluControl = A_MOV; dec.memToReg = 2'b01; end
          C_LSL: begin dec.regWrite = 1'b1; dec.aluControl = A_LSL; dec.memToReg = 2'b01; end
          C_LSR: begin dec.regWrite = 1'b1; dec.aluControl = A_LSR; dec.memToReg = 2'b01; end
          C_MUL: begin
            dec.regWrite = 1'b1; dec.aluControl = A_MUL; dec.memToReg = 2'b01; dec_mul = 1'b1;
          end
          C_CMP: begin dec.aluControl = A_SUB; dec.flagWrite = 1'b1; end
          C_SIN: begin dec.regWrite = 1'b1; dec.memToReg = 2'b11; dec_trig = 1'b1; end
          C_COS: begin
            dec.regWrite = 1'b1; dec.memToReg = 2'b11; dec.trigControl = 1'b1; dec_trig = 1'b1;
          end
          C_NOP:   ;
          default: dec_bad = 1'b1;
        endcase
        if (bus.in_imm && !dec_bad && bus.in_cmd != C_NOP) begin
          dec.aluSrc = 1'b1;
          dec.immSrc = 1'b0;
        end
      end
      OP_MEM: begin
        case (bus.in_cmd[1:0])
          2'b00: begin
            dec.regWrite = 1'b1; dec.aluSrc = 1'b1; dec.aluControl = A_ADD; dec.memToReg = 2'b00;
          end
          2'b01: begin
            dec.memWrite = 1'b1; dec.aluSrc = 1'b1; dec.aluControl = A_ADD; dec_a2 = 1'b1;
          end
          2'b10:   begin dec.regWrite = 1'b1; dec.memToReg = 2'b10; end
          default: begin dec.memPixWrite = 1'b1; dec_a2 = 1'b1; end
        endcase
      end
      OP_FLOW: begin
        dec_flow   = 1'b1;
        dec.branch = 1'b1;
        dec.pcSrc  = 1'b1;
        if (bus.in_cmd[0]) begin
          dec_link     = 1'b1;
          dec.regWrite = 1'b1;
        end
      end
      default: dec_bad = 1'b1;
    endcase
  end

  assign accept = bus.in_valid && (state_q != S_BUSY);
  assign trap   = TRAP_EN && dec_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      cnt_q       <= '0;
      sq_q        <= '0;
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      a2_q        <= 1'b0;
      link_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sq_q        <= sq_d;
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      a2_q        <= a2_d;
      link_q      <= link_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sq_d    = sq_q;
    case (state_q)
      S_RUN: begin
        if (accept && !trap) begin
          if (dec_mul && MUL_LAT > 1) begin
            state_d = S_BUSY;
            cnt_d   = CNT_W'(MUL_LAT - 1);
          end else if (dec_trig && TRIG_LAT > 1) begin
            state_d = S_BUSY;
            cnt_d   = CNT_W'(TRIG_LAT - 1);
          end else if (dec_flow && FLUSH_DEPTH > 0) begin
            state_d = S_SHADOW;
            sq_d    = 3'(FLUSH_DEPTH);
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_RUN;
      end
      S_SHADOW: begin
        // Only consumed slots count, so idle cycles leave the shadow open.
        if (accept) begin
          sq_d = sq_q - 3'd1;
          if (sq_q == 3'd1) state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    out_valid_d = 1'b0;
    ctrl_d      = '0;
    a2_d        = 1'b0;
    link_d      = 1'b0;
    if (state_q == S_RUN && accept && !trap) begin
      out_valid_d = 1'b1;
      ctrl_d      = dec;
      a2_d        = dec_a2;
      link_d      = dec_link;
    end
  end

`ifdef CU_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            illegal_q <= 1'b0;
    else if (accept && trap) illegal_q <= 1'b1;
  end
  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

  assign bus.stall      = (state_q == S_BUSY);
  assign bus.out_valid  = out_valid_q;
  assign bus.ctrl       = ctrl_q;
  assign bus.reg_src_a1 = 1'b0;
  assign bus.reg_src_a2 = a2_q;
  assign bus.b_link     = link_q;
endmodule
